adder_bist_engine: RTL and testbench

- On-chip built-in self-test engine wrapped around a combinational WIDTH-bit prefix adder (Brent-Kung, Kogge-Stone, etc.) for FPGA hardware validation.
- Upstream role: generates pseudo-random operand pairs and drives the adder's A/B inputs from registers.
- Downstream role: samples the adder's WIDTH+1-bit sum, checks it against a behavioural A+B, and counts mismatches.
- Reports done/pass/error count to a host register or LEDs.

---
 rtl/adder_bist_engine.sv | 169 ++++++++++++++++
 tb/tb_adder_bist_engine.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_bist_engine.sv
// BIST engine for a combinational WIDTH-bit adder: LFSR operand generation, sum checking and
// error counting. Optional first-failure capture is enabled by ADDER_BIST_FAIL_CAPTURE_EN.
module adder_bist_engine #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned NUM_VEC = 100000,
   parameter logic [31:0] SEED_A  = 32'h1234_5678,
   parameter logic [31:0] SEED_B  = 32'h9ABC_DEF0,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] dut_a,
   output logic [WIDTH-1:0] dut_b,
   input  logic [WIDTH:0]   dut_s,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] vec_count,
   output logic [CNT_W-1:0] err_count,
   output logic [WIDTH-1:0] fail_a,
   output logic [WIDTH-1:0] fail_b,
   output logic [WIDTH:0]   fail_s
);

   localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
   localparam logic [31:0] SEED_A_S  = (SEED_A == 32'h0) ? 32'h1 : SEED_A;
   localparam logic [31:0] SEED_B_S  = (SEED_B == 32'h0) ? 32'h1 : SEED_B;
   localparam int unsigned LW        = $clog2(NUM_VEC + 1);

   typedef enum logic [2:0] {StIdle, StLaunch0, StRun, StDrain, StDone} state_e;

   state_e           state_q, state_d;
   logic [31:0]      lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH:0]   exp_q, exp_d;
   logic [LW-1:0]    launch_q, launch_d;
   logic [CNT_W-1:0] vec_q, vec_d, err_q, err_d;
   logic             clear, launch, compare, mismatch;

   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      return {1'b0, v[31:1]} ^ (v[0] ? LFSR_MASK : 32'h0);
   endfunction

   assign clear    = ((state_q == StIdle) || (state_q == StDone)) && start;
   assign launch   = (state_q == StLaunch0) || (state_q == StRun);
   assign compare  = (state_q == StRun) || (state_q == StDrain);
   assign mismatch = compare && (dut_s != exp_q);

   always_comb begin
      state_d  = state_q;
      launch_d = launch_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) state_d = StLaunch0;
         end
         StLaunch0: begin
            launch_d = LW'(1);
            state_d  = (NUM_VEC == 1) ? StDrain : StRun;
         end
         StRun: begin
            launch_d = launch_q + LW'(1);
            if (launch_d == LW'(NUM_VEC)) state_d = StDrain;
         end
         StDrain: state_d = StDone;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      lfsr_a_d = lfsr_a_q;
      lfsr_b_d = lfsr_b_q;
      a_d      = a_q;
      b_d      = b_q;
      exp_d    = exp_q;
      vec_d    = vec_q;
      err_d    = err_q;
      if (clear) begin
         lfsr_a_d = SEED_A_S;
         lfsr_b_d = SEED_B_S;
         vec_d    = '0;
         err_d    = '0;
      end
      if (launch) begin
         a_d      = lfsr_a_q[WIDTH-1:0];
         b_d      = lfsr_b_q[WIDTH-1:0];
         // Full WIDTH+1-bit reference so the carry-out is checked too
         exp_d    = {1'b0, lfsr_a_q[WIDTH-1:0]} + {1'b0, lfsr_b_q[WIDTH-1:0]};
         lfsr_a_d = lfsr_step(lfsr_a_q);
         lfsr_b_d = lfsr_step(lfsr_b_q);
      end
      if (compare) vec_d = vec_q + CNT_W'(1);
      if (mismatch && (err_q != '1)) err_d = err_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         lfsr_a_q <= SEED_A_S;
         lfsr_b_q <= SEED_B_S;
         a_q      <= '0;
         b_q      <= '0;
         exp_q    <= '0;
         launch_q <= '0;
         vec_q    <= '0;
         err_q    <= '0;
      end else begin
         state_q  <= state_d;
         lfsr_a_q <= lfsr_a_d;
         lfsr_b_q <= lfsr_b_d;
         a_q      <= a_d;
         b_q      <= b_d;
         exp_q    <= exp_d;
         launch_q <= launch_d;
         vec_q    <= vec_d;
         err_q    <= err_d;
      end
   end

   assign dut_a     = a_q;
   assign dut_b     = b_q;
   assign busy      = (state_q == StLaunch0) || (state_q == StRun) || (state_q == StDrain);
   assign done      = (state_q == StDone);
   assign pass      = done && (err_q == '0);
   assign vec_count = vec_q;
   assign err_count = err_q;

`ifdef ADDER_BIST_FAIL_CAPTURE_EN
   logic [WIDTH-1:0] fail_a_q, fail_a_d, fail_b_q, fail_b_d;
   logic [WIDTH:0]   fail_s_q, fail_s_d;

   // err_q never wraps back to zero, so zero means no earlier mismatch in this run
   always_comb begin
      fail_a_d = fail_a_q;
      fail_b_d = fail_b_q;
      fail_s_d = fail_s_q;
      if (clear) begin
         fail_a_d = '0;
         fail_b_d = '0;
         fail_s_d = '0;
      end else if (mismatch && (err_q == '0)) begin
         fail_a_d = a_q;
         fail_b_d = b_q;
         fail_s_d = dut_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_a_q <= '0;
         fail_b_q <= '0;
         fail_s_q <= '0;
      end else begin
         fail_a_q <= fail_a_d;
         fail_b_q <= fail_b_d;
         fail_s_q <= fail_s_d;
      end
   end

   assign fail_a = fail_a_q;
   assign fail_b = fail_b_q;
   assign fail_s = fail_s_q;
`else
   assign fail_a = '0;
   assign fail_b = '0;
   assign fail_s = '0;
`endif

endmodule

// File: tb/tb_adder_bist_engine.sv
// Directed bench for adder_bist_engine: golden, +1-faulty, carry-fault and saturating adders.
module tb_adder_bist_engine;

   localparam logic [31:0] SA = 32'h1234_5678;
   localparam logic [31:0] SB = 32'h9ABC_DEF0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Instance g: NUM_VEC=16, golden or +1 adder
   logic        start_g, fault_g, busy_g, done_g, pass_g;
   logic [15:0] a_g, b_g, fa_g, fb_g;
   logic [16:0] s_g, fs_g;
   logic [31:0] vec_g, err_g;
   // Instance c: NUM_VEC=1000, carry-out stuck at 0
   logic        start_c, busy_c, done_c, pass_c;
   logic [15:0] a_c, b_c, fa_c, fb_c;
   logic [16:0] s_c, fs_c, sum_c;
   logic [31:0] vec_c, err_c;
   // Instance s: CNT_W=4, NUM_VEC=20, always wrong
   logic        start_s, busy_s, done_s, pass_s;
   logic [15:0] a_s, b_s, fa_s, fb_s;
   logic [16:0] s_s, fs_s;
   logic [3:0]  vec_s, err_s;

   always_comb s_g = 17'(a_g) + 17'(b_g) + 17'(fault_g);
   always_comb begin
      sum_c = 17'(a_c) + 17'(b_c);
      s_c   = {1'b0, sum_c[15:0]};
   end
   always_comb s_s = 17'(a_s) + 17'(b_s) + 17'd1;

   adder_bist_engine #(.WIDTH(16), .NUM_VEC(16)) u_g (
      .clk(clk), .rst_n(rst_n), .start(start_g), .dut_a(a_g), .dut_b(b_g), .dut_s(s_g),
      .busy(busy_g), .done(done_g), .pass(pass_g), .vec_count(vec_g), .err_count(err_g),
      .fail_a(fa_g), .fail_b(fb_g), .fail_s(fs_g)
   );

   adder_bist_engine #(.WIDTH(16), .NUM_VEC(1000)) u_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .dut_a(a_c), .dut_b(b_c), .dut_s(s_c),
      .busy(busy_c), .done(done_c), .pass(pass_c), .vec_count(vec_c), .err_count(err_c),
      .fail_a(fa_c), .fail_b(fb_c), .fail_s(fs_c)
   );

   adder_bist_engine #(.WIDTH(16), .NUM_VEC(20), .CNT_W(4)) u_s (
      .clk(clk), .rst_n(rst_n), .start(start_s), .dut_a(a_s), .dut_b(b_s), .dut_s(s_s),
      .busy(busy_s), .done(done_s), .pass(pass_s), .vec_count(vec_s), .err_count(err_s),
      .fail_a(fa_s), .fail_b(fb_s), .fail_s(fs_s)
   );

   function automatic logic [31:0] step(input logic [31:0] v);
      return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
      checks++;
      assert (obs === want) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   // Pulse start on u_g, follow the run to done, checking the operand stream against the model.
   task automatic run_g(input int mid_start_at, output int edges, output int busy_cyc,
                        output logic [15:0] last_a);
      logic [31:0] la, lb;
      la = SA;
      lb = SB;
      last_a = '0;
      edges = 0;
      busy_cyc = 0;
      start_g = 1'b1;
      @(negedge clk);
      start_g = 1'b0;
      check("clr_vec", vec_g, 0);
      check("clr_done", done_g, 0);
      for (int i = 0; i < 200 && !done_g; i++) begin
         if (busy_g) busy_cyc++;
         if (i >= 1 && i <= 16) begin
            check("op_a", a_g, la[15:0]);
            check("op_b", b_g, lb[15:0]);
            last_a = la[15:0];
            la = step(la);
            lb = step(lb);
         end
         if (i == mid_start_at) start_g = 1'b1;
         @(negedge clk);
         start_g = 1'b0;
         edges++;
      end
      check("done_seen", done_g, 1);
   endtask

   int          edges, busy_cyc, carries;
   logic [15:0] last_a;
   logic [31:0] ma, mb;

   initial begin
      start_g = 1'b0;
      start_c = 1'b0;
      start_s = 1'b0;
      fault_g = 1'b0;

      #2;
      check("rst_busy", busy_g, 0);
      check("rst_done", done_g, 0);
      check("rst_pass", pass_g, 0);
      check("rst_a", a_g, 0);
      check("rst_b", b_g, 0);
      check("rst_vec", vec_g, 0);
      check("rst_err", err_g, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", busy_g, 0);

      // Golden run
      run_g(-1, edges, busy_cyc, last_a);
      check("gold_edges", edges, 17);
      check("gold_busy_cycles", busy_cyc, 17);
      check("gold_vec", vec_g, 16);
      check("gold_err", err_g, 0);
      check("gold_pass", pass_g, 1);
      check("gold_busy_done", busy_g, 0);
      check("gold_fail_a", fa_g, 0);
      check("gold_fail_s", fs_g, 0);
      @(negedge clk);
      check("hold_a", a_g, last_a);
      check("hold_done", done_g, 1);

      // Faulty +1 adder, restarted from DONE, with an ignored start mid-run
      fault_g = 1'b1;
      run_g(5, edges, busy_cyc, last_a);
      check("fault_edges", edges, 17);
      check("fault_vec", vec_g, 16);
      check("fault_err", err_g, 16);
      check("fault_pass", pass_g, 0);
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
      check("fail_a", fa_g, 16'h5678);
      check("fail_b", fb_g, 16'hDEF0);
      check("fail_s", fs_g, 17'h1_3569);
`else
      check("fail_a_tied", fa_g, 0);
      check("fail_b_tied", fb_g, 0);
      check("fail_s_tied", fs_g, 0);
`endif

      // Identical golden rerun from DONE
      fault_g = 1'b0;
      run_g(-1, edges, busy_cyc, last_a);
      check("rerun_edges", edges, 17);
      check("rerun_vec", vec_g, 16);
      check("rerun_err", err_g, 0);
      check("rerun_pass", pass_g, 1);
      check("rerun_fail_a", fa_g, 0);

      // Carry-out stuck at 0: expected errors from the LFSR model
      ma = SA;
      mb = SB;
      carries = 0;
      for (int i = 0; i < 1000; i++) begin
         if ((17'(ma[15:0]) + 17'(mb[15:0])) >= 17'h1_0000) carries++;
         ma = step(ma);
         mb = step(mb);
      end
      start_c = 1'b1;
      @(negedge clk);
      start_c = 1'b0;
      for (int i = 0; i < 1200 && !done_c; i++) @(negedge clk);
      check("carry_done", done_c, 1);
      check("carry_vec", vec_c, 1000);
      check("carry_err", err_c, carries);
      check("carry_pass", pass_c, 0);

      // Saturating 4-bit counters
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      for (int i = 0; i < 60 && !done_s; i++) @(negedge clk);
      check("sat_done", done_s, 1);
      check("sat_vec", vec_s, 4);
      check("sat_err", err_s, 15);
      check("sat_pass", pass_s, 0);

      // Asynchronous reset mid-run
      start_g = 1'b1;
      @(negedge clk);
      start_g = 1'b0;
      for (int i = 0; i < 50 && vec_g != 8; i++) @(negedge clk);
      check("mid_vec8", vec_g, 8);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", busy_g, 0);
      check("arst_done", done_g, 0);
      check("arst_pass", pass_g, 0);
      check("arst_vec", vec_g, 0);
      check("arst_err", err_g, 0);
      check("arst_a", a_g, 0);
      check("arst_b", b_g, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_g(-1, edges, busy_cyc, last_a);
      check("post_rst_edges", edges, 17);
      check("post_rst_vec", vec_g, 16);
      check("post_rst_err", err_g, 0);
      check("post_rst_pass", pass_g, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
